// File: rtl/axi_bus_pkg.sv
// Shared write-path types for the AXI crossbar: slave map, route-select codes and FSM states.
package axi_bus_pkg;

  localparam int unsigned MX_SX_ID_BITS = 4;
  localparam int unsigned SLV_IDX_BITS  = 3;

  typedef enum logic [SLV_IDX_BITS-1:0] {
    SLV_S0 = 3'd0,
    SLV_S1 = 3'd1,
    SLV_S2 = 3'd2,
    SLV_S3 = 3'd3,
    SLV_S4 = 3'd4,
    SLV_S5 = 3'd5,
    SLV_SD = 3'd6
  } slave_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } wr_state_e;

  // Inclusive slave windows
  localparam logic [31:0] S0_BASE = 32'h0000_0000, S0_LIMIT = 32'h0000_3FFF;
  localparam logic [31:0] S1_BASE = 32'h0001_0000, S1_LIMIT = 32'h0001_FFFF;
  localparam logic [31:0] S2_BASE = 32'h0002_0000, S2_LIMIT = 32'h0002_FFFF;
  localparam logic [31:0] S3_BASE = 32'h1000_0000, S3_LIMIT = 32'h1000_03FF;
  localparam logic [31:0] S4_BASE = 32'h1001_0000, S4_LIMIT = 32'h1001_03FF;
  localparam logic [31:0] S5_BASE = 32'h2000_0000, S5_LIMIT = 32'h201F_FFFF;

  // Route select = {master, slave index}; 4'hF matches no route and gates every channel
  localparam logic [MX_SX_ID_BITS-1:0] M0_S0_W = 4'h0, M0_S1_W = 4'h1, M0_S2_W = 4'h2;
  localparam logic [MX_SX_ID_BITS-1:0] M0_S3_W = 4'h3, M0_S4_W = 4'h4, M0_S5_W = 4'h5;
  localparam logic [MX_SX_ID_BITS-1:0] M0_SD_W = 4'h6;
  localparam logic [MX_SX_ID_BITS-1:0] M1_S0_W = 4'h8, M1_S1_W = 4'h9, M1_S2_W = 4'hA;
  localparam logic [MX_SX_ID_BITS-1:0] M1_S3_W = 4'hB, M1_S4_W = 4'hC, M1_S5_W = 4'hD;
  localparam logic [MX_SX_ID_BITS-1:0] M1_SD_W = 4'hE;
  localparam logic [MX_SX_ID_BITS-1:0] SEL_IDLE = 4'hF;

  function automatic logic in_range(input logic [31:0] addr, input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

  function automatic logic [MX_SX_ID_BITS-1:0] route_code(input logic m1, input slave_e slv);
    return {m1, SLV_IDX_BITS'(slv)};
  endfunction

endpackage

// File: rtl/axi_addr_decoder.sv
// Combinational AWADDR -> slave index decode; unmapped addresses go to the default slave.
module axi_addr_decoder
  import axi_bus_pkg::*;
(
  input  logic [31:0] i_addr,
  output slave_e      o_slave_c
);

  always_comb begin
    o_slave_c = SLV_SD;
    if      (in_range(i_addr, S0_BASE, S0_LIMIT)) o_slave_c = SLV_S0;
    else if (in_range(i_addr, S1_BASE, S1_LIMIT)) o_slave_c = SLV_S1;
    else if (in_range(i_addr, S2_BASE, S2_LIMIT)) o_slave_c = SLV_S2;
    else if (in_range(i_addr, S3_BASE, S3_LIMIT)) o_slave_c = SLV_S3;
    else if (in_range(i_addr, S4_BASE, S4_LIMIT)) o_slave_c = SLV_S4;
    else if (in_range(i_addr, S5_BASE, S5_LIMIT)) o_slave_c = SLV_S5;
  end

endmodule

// File: rtl/axi_write_arbiter.sv
// Write-path arbiter/sequencer: one write in flight, route held from AW grant to B completion.
// Define WR_ARB_RR_EN for round-robin between M0/M1; otherwise fixed priority M1 > M0.
module axi_write_arbiter
  import axi_bus_pkg::*;
#(
  parameter int unsigned MAX_LEN = 16
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic                     AWVALID_M0,
  input  logic [31:0]              AWADDR_M0,
  input  logic                     AWVALID_M1,
  input  logic [31:0]              AWADDR_M1,
  input  logic                     AWREADY_M0,
  input  logic                     AWREADY_M1,
  input  logic [3:0]               AWLEN_G,
  input  logic                     WVALID_G,
  input  logic                     WREADY_G,
  input  logic                     WLAST_G,
  input  logic                     BVALID_G,
  input  logic                     BREADY_G,
  output logic [MX_SX_ID_BITS-1:0] AW_arbiter,
  output logic [MX_SX_ID_BITS-1:0] W_arbiter,
  output logic [MX_SX_ID_BITS-1:0] B_arbiter,
  output logic                     wlast_err
);

  localparam int unsigned CNT_W = $clog2(MAX_LEN) + 1;

  wr_state_e                r_state, w_next_state;
  logic [MX_SX_ID_BITS-1:0] r_code, w_next_code;
  logic [MX_SX_ID_BITS-1:0] w_aw_nxt, w_w_nxt, w_b_nxt;
  logic [3:0]               r_len, w_len_nxt;
  logic [CNT_W-1:0]         r_cnt, w_cnt_nxt;
  logic                     w_err_nxt;
  logic                     w_aw_hs, w_w_hs, w_b_hs;
  logic                     w_win_m1;
  slave_e                   w_slv_m0, w_slv_m1;

  axi_addr_decoder u_dec_m0 (.i_addr(AWADDR_M0), .o_slave_c(w_slv_m0));
  axi_addr_decoder u_dec_m1 (.i_addr(AWADDR_M1), .o_slave_c(w_slv_m1));

`ifdef WR_ARB_RR_EN
  // Priority pointer: 1 = M1 wins the next simultaneous request
  logic r_prio_m1;

  assign w_win_m1 = AWVALID_M1 & (~AWVALID_M0 | r_prio_m1);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_prio_m1 <= 1'b0;
    end else if ((r_state == ST_RESP) && w_b_hs) begin
      r_prio_m1 <= ~r_code[MX_SX_ID_BITS-1];
    end
  end
`else
  assign w_win_m1 = AWVALID_M1;
`endif

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state    <= ST_IDLE;
      r_code     <= SEL_IDLE;
      r_len      <= '0;
      r_cnt      <= '0;
      AW_arbiter <= SEL_IDLE;
      W_arbiter  <= SEL_IDLE;
      B_arbiter  <= SEL_IDLE;
      wlast_err  <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_code     <= w_next_code;
      r_len      <= w_len_nxt;
      r_cnt      <= w_cnt_nxt;
      AW_arbiter <= w_aw_nxt;
      W_arbiter  <= w_w_nxt;
      B_arbiter  <= w_b_nxt;
      wlast_err  <= w_err_nxt;
    end
  end

  // Selects are computed from the next state so each one is live exactly in its phase
  always_comb begin
    w_next_state = r_state;
    w_next_code  = r_code;
    w_len_nxt    = r_len;
    w_cnt_nxt    = r_cnt;
    w_err_nxt    = 1'b0;
    w_aw_hs      = r_code[MX_SX_ID_BITS-1] ? (AWVALID_M1 & AWREADY_M1)
                                           : (AWVALID_M0 & AWREADY_M0);
    w_w_hs       = WVALID_G & WREADY_G;
    w_b_hs       = BVALID_G & BREADY_G;

    case (r_state)
      ST_IDLE: begin
        if (AWVALID_M0 | AWVALID_M1) begin
          w_next_state = ST_ADDR;
          w_next_code  = route_code(w_win_m1, w_win_m1 ? w_slv_m1 : w_slv_m0);
        end
      end
      ST_ADDR: begin
        if (w_aw_hs) begin
          w_next_state = ST_DATA;
          w_len_nxt    = AWLEN_G;
          w_cnt_nxt    = '0;
        end
      end
      ST_DATA: begin
        if (w_w_hs) begin
          if (r_cnt != {CNT_W{1'b1}}) w_cnt_nxt = r_cnt + CNT_W'(1);
          // r_cnt is the zero-based index of this beat; WLAST belongs on index AWLEN
          if (WLAST_G) begin
            w_next_state = ST_RESP;
            w_err_nxt    = (r_cnt != CNT_W'(r_len));
          end else begin
            w_err_nxt    = (r_cnt >= CNT_W'(r_len));
          end
        end
      end
      ST_RESP: begin
        if (w_b_hs) begin
          w_next_state = ST_IDLE;
          w_next_code  = SEL_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_code  = SEL_IDLE;
      end
    endcase

    w_aw_nxt = (w_next_state == ST_ADDR) ? w_next_code : SEL_IDLE;
    w_w_nxt  = (w_next_state == ST_DATA) ? w_next_code : SEL_IDLE;
    w_b_nxt  = (w_next_state == ST_RESP) ? w_next_code : SEL_IDLE;
  end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Scoreboard bench for axi_write_arbiter: driver pushes expected routes/errors, monitor pops and compares.
module tb_axi_write_arbiter;
  import axi_bus_pkg::*;

  logic        ACLK = 1'b0, ARESETn = 1'b0;
  logic        AWVALID_M0 = 1'b0, AWVALID_M1 = 1'b0;
  logic [31:0] AWADDR_M0 = '0, AWADDR_M1 = '0;
  logic        AWREADY_M0 = 1'b0, AWREADY_M1 = 1'b0;
  logic [3:0]  AWLEN_G = '0;
  logic        WVALID_G = 1'b0, WREADY_G = 1'b0, WLAST_G = 1'b0;
  logic        BVALID_G = 1'b0, BREADY_G = 1'b0;
  logic [3:0]  AW_arbiter, W_arbiter, B_arbiter;
  logic        wlast_err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] exp_grant[$];
  bit         exp_err[$];
  bit         prio_m1 = 1'b0;

  axi_write_arbiter #(.MAX_LEN(16)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWVALID_M0(AWVALID_M0), .AWADDR_M0(AWADDR_M0),
    .AWVALID_M1(AWVALID_M1), .AWADDR_M1(AWADDR_M1),
    .AWREADY_M0(AWREADY_M0), .AWREADY_M1(AWREADY_M1),
    .AWLEN_G(AWLEN_G), .WVALID_G(WVALID_G), .WREADY_G(WREADY_G), .WLAST_G(WLAST_G),
    .BVALID_G(BVALID_G), .BREADY_G(BREADY_G),
    .AW_arbiter(AW_arbiter), .W_arbiter(W_arbiter), .B_arbiter(B_arbiter),
    .wlast_err(wlast_err)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Address map written straight from the slave table
  function automatic int ref_slave(input logic [31:0] a);
    if (a <= 32'h0000_3FFF) return 0;
    if (a >= 32'h0001_0000 && a <= 32'h0001_FFFF) return 1;
    if (a >= 32'h0002_0000 && a <= 32'h0002_FFFF) return 2;
    if (a >= 32'h1000_0000 && a <= 32'h1000_03FF) return 3;
    if (a >= 32'h1001_0000 && a <= 32'h1001_03FF) return 4;
    if (a >= 32'h2000_0000 && a <= 32'h201F_FFFF) return 5;
    return 6;
  endfunction

  function automatic logic [3:0] ref_code(input bit m1, input int s);
    logic [3:0] tbl0[7];
    logic [3:0] tbl1[7];
    tbl0 = '{M0_S0_W, M0_S1_W, M0_S2_W, M0_S3_W, M0_S4_W, M0_S5_W, M0_SD_W};
    tbl1 = '{M1_S0_W, M1_S1_W, M1_S2_W, M1_S3_W, M1_S4_W, M1_S5_W, M1_SD_W};
    return m1 ? tbl1[s] : tbl0[s];
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic clear_stim();
    AWVALID_M0 = 1'b0; AWVALID_M1 = 1'b0; AWREADY_M0 = 1'b0; AWREADY_M1 = 1'b0;
    AWLEN_G = '0; WVALID_G = 1'b0; WREADY_G = 1'b0; WLAST_G = 1'b0;
    BVALID_G = 1'b0; BREADY_G = 1'b0;
  endtask

  task automatic recover();
    ARESETn = 1'b0;
    clear_stim();
    exp_grant.delete();
    exp_err.delete();
    prio_m1 = 1'b0;
    tick();
    tick();
    ARESETn = 1'b1;
  endtask

  task automatic issue(input bit v0, input logic [31:0] a0, input bit v1, input logic [31:0] a1);
    AWVALID_M0 = v0; AWADDR_M0 = a0;
    AWVALID_M1 = v1; AWADDR_M1 = a1;
  endtask

  // Plays crossbar + slave for one granted transaction; rst_after >= 0 resets after that many beats
  task automatic serve(input int len, input int beats, input int rst_after);
    bit          win;
    bit          got;
    bit          last;
    int          t;
    logic [31:0] addr;
`ifdef WR_ARB_RR_EN
    win = (AWVALID_M0 && AWVALID_M1) ? prio_m1 : AWVALID_M1;
`else
    win = AWVALID_M1;
`endif
    addr = win ? AWADDR_M1 : AWADDR_M0;
    exp_grant.push_back(ref_code(win, ref_slave(addr)));

    got = 1'b0;
    t = 0;
    while (!got && t < 20) begin
      tick();
      got = (AW_arbiter != SEL_IDLE);
      t++;
    end
    if (!got) begin
      fail_now("grant_timeout");
      recover();
      return;
    end

    if (win) AWREADY_M1 = 1'b1; else AWREADY_M0 = 1'b1;
    AWLEN_G = 4'(len);
    tick();
    AWREADY_M0 = 1'b0; AWREADY_M1 = 1'b0;
    if (win) AWVALID_M1 = 1'b0; else AWVALID_M0 = 1'b0;

    for (int i = 0; i < beats; i++) begin
      if (i == rst_after) begin
        ARESETn = 1'b0;
        #1;
        check("rst_aw_idle", 32'(AW_arbiter), 32'(SEL_IDLE));
        check("rst_w_idle",  32'(W_arbiter),  32'(SEL_IDLE));
        check("rst_b_idle",  32'(B_arbiter),  32'(SEL_IDLE));
        check("rst_err_low", 32'(wlast_err),  32'd0);
        clear_stim();
        exp_err.delete();
        prio_m1 = 1'b0;
        tick();
        ARESETn = 1'b1;
        return;
      end
      last = (i == beats - 1);
      exp_err.push_back(last ? (i != len) : (i >= len));
      WVALID_G = 1'b1; WREADY_G = 1'b1; WLAST_G = last;
      tick();
    end
    WVALID_G = 1'b0; WREADY_G = 1'b0; WLAST_G = 1'b0;

    BVALID_G = 1'b1; BREADY_G = 1'b1;
    tick();
    BVALID_G = 1'b0; BREADY_G = 1'b0;
    check("bubble_aw_idle", 32'(AW_arbiter), 32'(SEL_IDLE));
    prio_m1 = !win;
  endtask

  // Monitor: route on each select's rising phase, wlast_err one cycle after each W beat
  initial begin
    logic [3:0] prev_aw, prev_w, prev_b, cur_code;
    bit         pend, pend_v;
    prev_aw = SEL_IDLE; prev_w = SEL_IDLE; prev_b = SEL_IDLE; cur_code = SEL_IDLE;
    pend = 1'b0; pend_v = 1'b0;
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        prev_aw = SEL_IDLE; prev_w = SEL_IDLE; prev_b = SEL_IDLE;
        pend = 1'b0;
      end else begin
        check("wlast_err", 32'(wlast_err), pend ? 32'(pend_v) : 32'd0);
        pend = 1'b0;
        if (AW_arbiter != SEL_IDLE && prev_aw == SEL_IDLE) begin
          if (exp_grant.size() == 0) begin
            fail_now("aw_unexpected_grant");
          end else begin
            cur_code = exp_grant.pop_front();
            check("aw_route", 32'(AW_arbiter), 32'(cur_code));
          end
        end
        if (W_arbiter != SEL_IDLE && prev_w == SEL_IDLE)
          check("w_route", 32'(W_arbiter), 32'(cur_code));
        if (B_arbiter != SEL_IDLE && prev_b == SEL_IDLE)
          check("b_route", 32'(B_arbiter), 32'(cur_code));
        if (W_arbiter != SEL_IDLE && WVALID_G && WREADY_G) begin
          if (exp_err.size() == 0) begin
            fail_now("w_beat_unexpected");
          end else begin
            pend   = 1'b1;
            pend_v = exp_err.pop_front();
          end
        end
        prev_aw = AW_arbiter; prev_w = W_arbiter; prev_b = B_arbiter;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout at %0t", $time);
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [31:0] bnd[13];
    logic [31:0] a;
    bit          v0, v1;
    int          len, beats;
    bnd = '{32'h0000_0000, 32'h0000_3FFF, 32'h0000_4000, 32'h0001_0000, 32'h0002_FFFF,
            32'h0003_0000, 32'h1000_03FF, 32'h1000_0400, 32'h1001_0000, 32'h1001_03FF,
            32'h2000_0000, 32'h201F_FFFF, 32'h2020_0000};

    clear_stim();
    ARESETn = 1'b0;
    tick();
    tick();
    check("reset_aw", 32'(AW_arbiter), 32'(SEL_IDLE));
    check("reset_w",  32'(W_arbiter),  32'(SEL_IDLE));
    check("reset_b",  32'(B_arbiter),  32'(SEL_IDLE));
    check("reset_err", 32'(wlast_err), 32'd0);
    ARESETn = 1'b1;
    tick();

    issue(1'b1, 32'h0001_0040, 1'b0, 32'h0);
    serve(3, 4, -1);

    for (int p = 0; p < 4; p++) begin
      issue(1'b1, 32'h2000_0000, 1'b1, 32'h2000_0000);
      serve(p, p + 1, -1);
      serve(1, 2, -1);
    end

    issue(1'b0, 32'h0, 1'b1, 32'h3000_0000);
    serve(2, 3, -1);

    issue(1'b1, 32'h1000_0010, 1'b0, 32'h0);
    serve(1, 1, -1);

    issue(1'b1, 32'h0002_0000, 1'b0, 32'h0);
    serve(3, 4, 2);
    issue(1'b0, 32'h0, 1'b1, 32'h1001_0000);
    serve(0, 1, -1);

    for (int i = 0; i < 13; i++) begin
      v1 = 1'($urandom_range(0, 1));
      issue(!v1, bnd[i], v1, bnd[i]);
      len = $urandom_range(0, 3);
      serve(len, len + 1, -1);
    end

    for (int i = 0; i < 60; i++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      a = $urandom_range(0, 1) ? bnd[$urandom_range(0, 12)] : $urandom;
      issue(v0, a, v1, $urandom_range(0, 1) ? bnd[$urandom_range(0, 12)] : $urandom);
      len   = $urandom_range(0, 15);
      beats = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 18) : len + 1;
      serve(len, beats, -1);
    end

    clear_stim();
    tick();
    tick();
    check("grant_queue_drained", 32'(exp_grant.size()), 32'd0);
    check("err_queue_drained",   32'(exp_err.size()),   32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
